// File: rtl/yasac_host.sv
// yasac_host: host-side run controller for a YASAC processor.
// Resets the core, loads input ports, starts it and waits for RDY under a watchdog.
module yasac_host #(
  parameter int unsigned SETTLE      = 3,
  parameter int unsigned TIMEOUT_CYC = 1000,
  parameter int unsigned CW          = 16
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic          GO,
  input  logic [63:0]   IN_BUS,
  input  logic          CPU_RDY,
  input  logic [63:0]   CPU_OUT,
  output logic          CPU_RESET,
  output logic          CPU_START,
  output logic [63:0]   CPU_IN,
  output logic          BUSY,
  output logic          DONE,
  output logic          TIMEOUT,
  output logic [63:0]   CAP,
  output logic [CW-1:0] CYCLES
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_RST  = 3'd1;
  localparam logic [2:0] S_SETL = 3'd2;
  localparam logic [2:0] S_STRT = 3'd3;
  localparam logic [2:0] S_WAIT = 3'd4;
  localparam logic [2:0] S_DONE = 3'd5;

  localparam logic [3:0]    SET_LAST = 4'(SETTLE - 1);
  localparam logic [CW-1:0] TO_LIM   = CW'(TIMEOUT_CYC);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic [2:0]    state_q, state_d;
  logic [3:0]    set_q, set_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          arm_q, arm_d;
  logic          rst_q, rst_d;
  logic          start_q, start_d;
  logic [63:0]   cin_q, cin_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          to_q, to_d;
  logic [63:0]   cap_q, cap_d;
  logic [CW-1:0] cyc_q, cyc_d;
  logic [CW-1:0] cnt_inc;

  assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + CNT_ONE;

  always_comb begin
    state_d = state_q;
    set_d   = set_q;
    cnt_d   = cnt_q;
    arm_d   = arm_q;
    rst_d   = 1'b0;
    start_d = 1'b0;
    cin_d   = cin_q;
    busy_d  = busy_q;
    done_d  = done_q;
    to_d    = to_q;
    cap_d   = cap_q;
    cyc_d   = cyc_q;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (GO) begin
          state_d = S_RST;
          cin_d   = IN_BUS;
          rst_d   = 1'b1;
          busy_d  = 1'b1;
          done_d  = 1'b0;
          to_d    = 1'b0;
        end
      end
      S_RST: begin
        state_d = S_SETL;
        set_d   = '0;
      end
      S_SETL: begin
        if (set_q == SET_LAST) begin
          state_d = S_STRT;
          start_d = 1'b1;
        end else begin
          set_d = set_q + 4'd1;
        end
      end
      S_STRT: begin
        // RDY must be seen low after START before a high counts
        arm_d   = ~CPU_RDY;
        cnt_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        cnt_d = cnt_inc;
        if (!CPU_RDY) arm_d = 1'b1;
        if (arm_q && CPU_RDY) begin
          state_d = S_DONE;
          cap_d   = CPU_OUT;
          cyc_d   = cnt_inc;
          to_d    = 1'b0;
          done_d  = 1'b1;
          busy_d  = 1'b0;
        end else if (cnt_inc == TO_LIM) begin
          state_d = S_DONE;
          cyc_d   = TO_LIM;
          to_d    = 1'b1;
          done_d  = 1'b1;
          busy_d  = 1'b0;
        end
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q <= S_IDLE;
      set_q   <= '0;
      cnt_q   <= '0;
      arm_q   <= 1'b0;
      rst_q   <= 1'b0;
      start_q <= 1'b0;
      cin_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      to_q    <= 1'b0;
      cap_q   <= '0;
      cyc_q   <= '0;
    end else begin
      state_q <= state_d;
      set_q   <= set_d;
      cnt_q   <= cnt_d;
      arm_q   <= arm_d;
      rst_q   <= rst_d;
      start_q <= start_d;
      cin_q   <= cin_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      to_q    <= to_d;
      cap_q   <= cap_d;
      cyc_q   <= cyc_d;
    end
  end

  assign CPU_RESET = rst_q;
  assign CPU_START = start_q;
  assign CPU_IN    = cin_q;
  assign BUSY      = busy_q;
  assign DONE      = done_q;
  assign TIMEOUT   = to_q;
  assign CAP       = cap_q;
  assign CYCLES    = cyc_q;

endmodule

// File: tb/tb_yasac_host.sv
// tb_yasac_host: directed and random runs against a simple
// run-outcome model of the host controller.
module tb_yasac_host;

  localparam int SETTLE = 3;
  localparam int TO     = 20;
  localparam int CW     = 16;

  logic          CLK = 1'b0;
  logic          RESET = 1'b0;
  logic          GO = 1'b0;
  logic [63:0]   IN_BUS = '0;
  logic          CPU_RDY = 1'b1;
  logic [63:0]   CPU_OUT = '0;
  logic          CPU_RESET, CPU_START, BUSY, DONE, TIMEOUT;
  logic [63:0]   CPU_IN, CAP;
  logic [CW-1:0] CYCLES;

  yasac_host #(
    .SETTLE(SETTLE), .TIMEOUT_CYC(TO), .CW(CW)
  ) dut (
    .CLK(CLK), .RESET(RESET), .GO(GO), .IN_BUS(IN_BUS),
    .CPU_RDY(CPU_RDY), .CPU_OUT(CPU_OUT),
    .CPU_RESET(CPU_RESET), .CPU_START(CPU_START),
    .CPU_IN(CPU_IN), .BUSY(BUSY), .DONE(DONE),
    .TIMEOUT(TIMEOUT), .CAP(CAP), .CYCLES(CYCLES)
  );

  always #5 CLK = ~CLK;

  int n_tests = 0;
  int n_fail  = 0;
  int start_tot = 0;
  int rst_tot   = 0;
  logic [63:0] ref_cap = '0;

  always @(negedge CLK) begin
    if (CPU_START === 1'b1) start_tot++;
    if (CPU_RESET === 1'b1) rst_tot++;
  end

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_rst"}, 64'(CPU_RESET), 64'd0);
    chk({tag, "_start"}, 64'(CPU_START), 64'd0);
    chk({tag, "_cin"}, CPU_IN, 64'd0);
    chk({tag, "_busy"}, 64'(BUSY), 64'd0);
    chk({tag, "_done"}, 64'(DONE), 64'd0);
    chk({tag, "_to"}, 64'(TIMEOUT), 64'd0);
    chk({tag, "_cap"}, CAP, 64'd0);
    chk({tag, "_cyc"}, 64'(CYCLES), 64'd0);
  endtask

  // One run: n = WAIT cycle at which RDY is seen high again.
  task automatic run(input logic [63:0] din, input int n,
                     input bit stuck, input logic [63:0] dout,
                     input bit noise, input int abort_at);
    int s0, r0, cyc, t, exp_cyc;
    bit exp_to;
    logic [63:0] prev_cap;
    s0 = start_tot;
    r0 = rst_tot;
    prev_cap = ref_cap;
    IN_BUS = din;
    GO = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    GO = 1'b0;
    chk("acc_busy", 64'(BUSY), 64'd1);
    chk("acc_cpurst", 64'(CPU_RESET), 64'd1);
    chk("acc_done", 64'(DONE), 64'd0);
    chk("acc_to", 64'(TIMEOUT), 64'd0);
    chk("acc_cin", CPU_IN, din);
    chk("acc_cap", CAP, prev_cap);
    cyc = 0;
    while (CPU_START !== 1'b1 && cyc < 40) begin
      if (noise && cyc == 2) begin
        GO = 1'b1;
        IN_BUS = ~din;
      end else GO = 1'b0;
      @(posedge CLK);
      cyc++;
      @(negedge CLK);
    end
    GO = 1'b0;
    chk("start_delay", 64'(cyc), 64'(SETTLE + 1));
    CPU_RDY = stuck;
    CPU_OUT = dout;
    t = 0;
    while (DONE !== 1'b1 && t < TO + 10) begin
      GO = (noise && t == 3);
      @(posedge CLK);
      t++;
      @(negedge CLK);
      if (abort_at > 0 && t == abort_at) begin
        GO = 1'b0;
        #2 RESET = 1'b0;
        #1 chk_zero("abort");
        @(negedge CLK);
        RESET = 1'b1;
        ref_cap = '0;
        return;
      end
      if (!stuck && t == n) CPU_RDY = 1'b1;
    end
    GO = 1'b0;
    if (!stuck && n <= TO) begin
      exp_cyc = n;
      exp_to  = 1'b0;
      ref_cap = dout;
    end else begin
      exp_cyc = TO;
      exp_to  = 1'b1;
    end
    chk("done_time", 64'(t), 64'(exp_cyc + 1));
    chk("done", 64'(DONE), 64'd1);
    chk("timeout", 64'(TIMEOUT), 64'(exp_to));
    chk("cycles", 64'(CYCLES), 64'(exp_cyc));
    chk("cap", CAP, ref_cap);
    chk("busy_end", 64'(BUSY), 64'd0);
    chk("cin_held", CPU_IN, din);
    chk("start_pulses", 64'(start_tot - s0), 64'd1);
    chk("reset_pulses", 64'(rst_tot - r0), 64'd1);
  endtask

  initial begin
    int n;
    bit st, nz;
    repeat (2) @(negedge CLK);
    chk_zero("init");
    RESET = 1'b1;
    @(negedge CLK);
    chk("idle_done", 64'(DONE), 64'd0);

    run(64'h0F0E0D0C0B0A0908, 10, 1'b0, 64'h1122334455667788, 1'b0, 0);
    run({$urandom, $urandom}, 25, 1'b0, {$urandom, $urandom}, 1'b0, 0);
    run({$urandom, $urandom}, 0, 1'b1, {$urandom, $urandom}, 1'b0, 0);
    run({$urandom, $urandom}, 20, 1'b0, {$urandom, $urandom}, 1'b0, 0);
    run({$urandom, $urandom}, 21, 1'b0, {$urandom, $urandom}, 1'b0, 0);
    run({$urandom, $urandom}, 1, 1'b0, {$urandom, $urandom}, 1'b0, 0);
    run({$urandom, $urandom}, 12, 1'b0, {$urandom, $urandom}, 1'b1, 0);
    run({$urandom, $urandom}, 15, 1'b0, {$urandom, $urandom}, 1'b0, 6);
    @(negedge CLK);
    chk("post_abort_done", 64'(DONE), 64'd0);
    run({$urandom, $urandom}, 7, 1'b0, {$urandom, $urandom}, 1'b0, 0);

    for (int i = 0; i < 10; i++) begin
      n  = int'($urandom_range(1, 24));
      st = ($urandom_range(0, 4) == 0);
      nz = (n >= 3) && $urandom_range(0, 1) == 1;
      run({$urandom, $urandom}, n, st, {$urandom, $urandom}, nz, 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
